// File: rtl/spi_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_pkg - state encoding, clog2 helper and default parameters. Rev 1.0
// ------------------------------------------------------------------
package spi_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_CS     = 4;
  localparam int DEF_DIV_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    GAP   = 3'd3,
    HOLD  = 3'd4,
    CSOFF = 3'd5
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int cs_width(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_clk_gen - half-period counter, SCLK edge strobes, registered SCLK. Rev 1.0
// ------------------------------------------------------------------
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run,
  input  logic                 toggle,
  input  logic                 cpol,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] cnt;

  // tick marks the last cycle of a half-period; sclk flips on the following clock edge
  assign tick       = run && (cnt == '0);
  assign lead_edge  = tick && toggle && (sclk == cpol);
  assign trail_edge = tick && toggle && (sclk != cpol);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (start)
        cnt <= div;
      else if (run)
        cnt <= (cnt == '0) ? div : cnt - DIV_WIDTH'(1);

      if (toggle) begin
        if (tick)
          sclk <= ~sclk;
      end else begin
        sclk <= cpol;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master_burst.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_master_burst - multi-word SPI master, all modes, runtime divider. Rev 1.0
// ------------------------------------------------------------------
module spi_master_burst
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CS     = DEF_NUM_CS,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_cpol,
  input  logic                          cfg_cpha,
  input  logic                          cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [cs_width(NUM_CS)-1:0]   cfg_cs_sel,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_last,
  output logic                          rx_valid,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          busy,
  output logic                          sclk,
  output logic                          mosi,
  output logic [NUM_CS-1:0]             cs_n,
  input  logic                          miso
);

  localparam int CS_W = cs_width(NUM_CS);
  localparam int EW   = clog2(2 * DATA_WIDTH) + 1;
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  state_t                state;
  logic                  cpol_q, cpha_q, lsb_q, last_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DATA_WIDTH-1:0] tsr, rsr, rx_next;
  logic [EW-1:0]         edge_cnt;
  logic                  tick, lead_edge, trail_edge;
  logic                  handshake, do_shift, do_sample;

  assign handshake = tx_valid && tx_ready;

  // Config is only live while idle; a burst runs entirely on the latched copy
  spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (handshake),
    .run        (state == SETUP || state == XFER || state == HOLD || state == CSOFF),
    .toggle     (state == SETUP || state == XFER),
    .cpol       ((state == IDLE) ? cfg_cpol : cpol_q),
    .div        ((state == IDLE) ? cfg_div : div_q),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .sclk       (sclk)
  );

  // The SETUP terminal tick is edge 0, so the first leading edge never shifts
  assign do_shift  = cpha_q ? (lead_edge && edge_cnt != '0)
                            : (trail_edge && edge_cnt != LAST_EDGE);
  assign do_sample = cpha_q ? trail_edge : lead_edge;
  assign rx_next   = !do_sample ? rsr :
                     lsb_q ? {miso, rsr[DATA_WIDTH-1:1]} : {rsr[DATA_WIDTH-2:0], miso};

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) m[i] = 1'b0;
    return m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      cs_n     <= '1;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      last_q   <= 1'b0;
      div_q    <= '0;
      tsr      <= '0;
      rsr      <= '0;
      edge_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (do_shift) begin
        tsr  <= lsb_q ? (tsr >> 1) : (tsr << 1);
        mosi <= lsb_q ? tsr[1] : tsr[DATA_WIDTH-2];
      end
      rsr <= rx_next;
      if (tick && (state == SETUP || state == XFER))
        edge_cnt <= edge_cnt + EW'(1);

      case (state)
        IDLE: if (handshake) begin
          cpol_q   <= cfg_cpol;
          cpha_q   <= cfg_cpha;
          lsb_q    <= cfg_lsb_first;
          div_q    <= cfg_div;
          last_q   <= tx_last;
          tsr      <= tx_data;
          mosi     <= cfg_lsb_first ? tx_data[0] : tx_data[DATA_WIDTH-1];
          cs_n     <= cs_decode(cfg_cs_sel);
          edge_cnt <= '0;
          tx_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= SETUP;
        end
        SETUP: if (tick) state <= XFER;
        XFER: if (tick && edge_cnt == LAST_EDGE) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          if (last_q) begin
            state <= HOLD;
          end else begin
            state    <= GAP;
            tx_ready <= 1'b1;
          end
        end
        GAP: if (handshake) begin
          last_q   <= tx_last;
          tsr      <= tx_data;
          mosi     <= lsb_q ? tx_data[0] : tx_data[DATA_WIDTH-1];
          edge_cnt <= '0;
          tx_ready <= 1'b0;
          state    <= SETUP;
        end
        HOLD: if (tick) begin
          cs_n  <= '1;
          state <= CSOFF;
        end
        CSOFF: if (tick) begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_burst.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_spi_master_burst - directed bench with mosi-bit and rx-word scoreboards. Rev 1.0
// ------------------------------------------------------------------
module tb_spi_master_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [7:0] cfg_div = 8'd1;
  logic [1:0] cfg_cs_sel = 2'd0;
  logic       tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, busy, sclk, mosi, miso;
  logic [7:0] rx_data;
  logic [3:0] cs_n;

  logic       loopback = 1'b1;
  logic [7:0] slave_sr = 8'h00;

  spi_master_burst #(.DATA_WIDTH(8), .NUM_CS(4), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_div(cfg_div), .cfg_cs_sel(cfg_cs_sel),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
    .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk),
    .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents its MSB first and shifts on falling SCLK
  assign miso = loopback ? mosi : slave_sr[7];
  always @(negedge sclk) if (!loopback) slave_sr <= {slave_sr[6:0], 1'b0};

  int checks = 0, errors = 0;
  int cyc = 0, edges, first_edge_cyc, last_edge_cyc, cs_fall_cyc, cs_rise_cyc;
  int cs_rises, rxv, hp_min, hp_max, iv;
  logic       prev_sclk = 1'b0;
  logic [3:0] prev_cs = 4'hF;
  logic       m_cpol = 1'b0, m_cpha = 1'b0, exp_bit;
  bit         bit_chk = 1'b1;
  logic       bit_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1 && sclk !== prev_sclk) begin
      edges++;
      if (edges == 1) first_edge_cyc = cyc;
      else if ((edges - 1) % 16 != 0) begin
        iv = cyc - last_edge_cyc;
        if (iv < hp_min) hp_min = iv;
        if (iv > hp_max) hp_max = iv;
      end
      last_edge_cyc = cyc;
      if (bit_chk && ((sclk != m_cpol) ^ m_cpha)) begin
        exp_bit = (bit_q.size() != 0) ? bit_q.pop_front() : 1'bx;
        chk("mosi_at_sample_edge", mosi, exp_bit);
      end
    end
    prev_sclk = sclk;
    if (cs_n !== prev_cs) begin
      if (prev_cs === 4'hF) cs_fall_cyc = cyc;
      if (cs_n === 4'hF) begin cs_rise_cyc = cyc; cs_rises++; end
    end
    prev_cs = cs_n;
    if (rx_valid === 1'b1) begin
      rxv++;
      exp_rx = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
      chk("rx_data", rx_data, exp_rx);
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    edges = 0; hp_min = 1000; hp_max = 0; cs_rises = 0; rxv = 0;
    first_edge_cyc = 0; last_edge_cyc = 0; cs_fall_cyc = 0; cs_rise_cyc = 0;
  endtask

  task automatic push_bits(input logic [7:0] d, input logic lsb);
    for (int i = 0; i < 8; i++) bit_q.push_back(lsb ? d[i] : d[7-i]);
  endtask

  task automatic send_word(input logic [7:0] d, input logic lst);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d; tx_last = lst;
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("tx_ready_timeout", n < 2000, 1);
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("gap_timeout", n < 2000, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
    chk("idle_timeout", n < 4000, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    rst = 1'b0;

    // Mode 0, MSB-first, div=1, slave returns 0x3C
    loopback = 1'b0; slave_sr = 8'h3C;
    clear_mon(); m_cpol = 0; m_cpha = 0;
    push_bits(8'hA5, 0); rx_q.push_back(8'h3C);
    send_word(8'hA5, 1);
    chk("m0_cs_low", cs_n, 4'b1110);
    chk("m0_busy", busy, 1);
    chk("m0_tx_ready_setup", tx_ready, 0);
    chk("m0_first_bit", mosi, 1);
    wait_idle();
    chk("m0_edges", edges, 16);
    chk("m0_rx_pulses", rxv, 1);
    chk("m0_first_edge_delay", first_edge_cyc - cs_fall_cyc, 2);
    chk("m0_hold_time", cs_rise_cyc - last_edge_cyc, 2);
    chk("m0_hp_min", hp_min, 2);
    chk("m0_hp_max", hp_max, 2);
    chk("m0_bits_left", bit_q.size(), 0);
    loopback = 1'b1;

    // All four modes, div=0, loopback 0x81
    for (int m = 0; m < 4; m++) begin
      cfg_cpol = m[1]; cfg_cpha = m[0]; cfg_div = 8'd0;
      repeat (3) @(negedge clk);
      chk($sformatf("idle_sclk_mode%0d", m), sclk, m[1]);
      clear_mon(); m_cpol = m[1]; m_cpha = m[0];
      push_bits(8'h81, 0); rx_q.push_back(8'h81);
      send_word(8'h81, 1);
      wait_idle();
      chk($sformatf("edges_mode%0d", m), edges, 16);
      chk($sformatf("rx_pulses_mode%0d", m), rxv, 1);
      chk($sformatf("hp_mode%0d", m), hp_max, 1);
      chk($sformatf("end_sclk_mode%0d", m), sclk, m[1]);
    end
    cfg_cpol = 0; cfg_cpha = 0;

    // Three-word burst to slave 2 with a 5-cycle stall before word 2
    cfg_div = 8'd1; cfg_cs_sel = 2'd2;
    clear_mon(); m_cpol = 0; m_cpha = 0;
    push_bits(8'h11, 0); rx_q.push_back(8'h11);
    send_word(8'h11, 0);
    chk("burst_cs_sel", cs_n, 4'b1011);
    wait_ready();
    for (int i = 0; i < 5; i++) begin
      chk("gap_cs_n", cs_n, 4'b1011);
      chk("gap_sclk", sclk, 0);
      chk("gap_busy", busy, 1);
      @(negedge clk);
    end
    push_bits(8'h22, 0); rx_q.push_back(8'h22);
    send_word(8'h22, 0);
    push_bits(8'h33, 0); rx_q.push_back(8'h33);
    send_word(8'h33, 1);
    n = 0;
    while (cs_n !== 4'hF && n < 2000) begin @(negedge clk); n++; end
    chk("csoff_tx_ready", tx_ready, 0);
    chk("csoff_busy", busy, 1);
    wait_idle();
    chk("burst_rx_pulses", rxv, 3);
    chk("burst_edges", edges, 48);
    chk("burst_cs_rises", cs_rises, 1);
    cfg_cs_sel = 2'd0;

    // LSB-first
    cfg_lsb_first = 1'b1;
    clear_mon();
    push_bits(8'h01, 1); rx_q.push_back(8'h01);
    send_word(8'h01, 1);
    chk("lsb_first_bit", mosi, 1);
    wait_idle();
    chk("lsb_rx_pulses", rxv, 1);
    cfg_lsb_first = 1'b0;

    // Reset after edge 5
    bit_chk = 1'b0;
    clear_mon();
    send_word(8'hF0, 1);
    n = 0;
    while (edges < 5 && n < 500) begin @(negedge clk); n++; end
    chk("rst_wait_edges", n < 500, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sclk", sclk, 0);
    chk("midrst_cs_n", cs_n, 4'hF);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_rx_data", rx_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_rx_valid", rxv, 0);
    bit_chk = 1'b1;
    clear_mon();
    push_bits(8'h5A, 0); rx_q.push_back(8'h5A);
    send_word(8'h5A, 1);
    wait_idle();
    chk("post_rst_edges", edges, 16);
    chk("post_rst_rx_pulses", rxv, 1);

    // Divider change during GAP applies only to the next burst
    cfg_cs_sel = 2'd1;
    clear_mon();
    push_bits(8'h55, 0); rx_q.push_back(8'h55);
    send_word(8'h55, 0);
    wait_ready();
    cfg_div = 8'd7;
    push_bits(8'hAA, 0); rx_q.push_back(8'hAA);
    send_word(8'hAA, 1);
    wait_idle();
    chk("cfgchg_hp_min", hp_min, 2);
    chk("cfgchg_hp_max", hp_max, 2);
    chk("cfgchg_edges", edges, 32);
    clear_mon();
    push_bits(8'hC3, 0); rx_q.push_back(8'hC3);
    send_word(8'hC3, 1);
    wait_idle();
    chk("div7_hp_min", hp_min, 8);
    chk("div7_hp_max", hp_max, 8);
    chk("div7_first_edge_delay", first_edge_cyc - cs_fall_cyc, 8);

    chk("rx_q_drained", rx_q.size(), 0);
    chk("bit_q_drained", bit_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
